// File: rtl/alu_rr_serial_sched.sv
// alu_rr_serial_sched
// Round-robin scheduler in front of a single bit-serial add/sub/compare cell.
// Two requesters compete for the engine. The winner's opcode and operands are
// latched, then one full-adder cell processes them LSB-first over WIDTH
// cycles. The registered result is held until the consumer takes it.
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake for requester N (N = 0, 1)
//   reqN_op                    00=ADD, 01=SUB, 10=CMP, 11=reserved
//   reqN_a, reqN_b             WIDTH-bit operands
//   rsp_valid / rsp_ready      result handshake
//   rsp_id                     requester that owns the result
//   rsp_result                 WIDTH+1 bit result, MSB is carry / borrow
//   rsp_err                    reserved opcode was issued
module alu_rr_serial_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_result,
  output logic             rsp_err
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             grant0, grant1;
  logic             last_grant_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             id_q;
  logic             carry_q, zero_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             last_bit;

  logic [1:0]       op_in;
  logic [WIDTH-1:0] a_in, b_in;
  logic             bit_a, bit_b, sum_bit, carry_d, zero_d;
  logic [WIDTH:0]   result_d;

  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and grant. A grant only ever goes to a valid requester, so a
  // grant is the accept condition. Under contention the requester that was
  // not served last wins; last_grant resets to 1 so req0 wins first.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_grant_q)) grant0 = 1'b1;
        else if (req1_valid)                             grant1 = 1'b1;
        if (grant0 || grant1) state_d = CALC;
      end
      CALC: if (last_bit)  state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == DONE);

  assign op_in = grant1 ? req1_op : req0_op;
  assign a_in  = grant1 ? req1_a  : req0_a;
  assign b_in  = grant1 ? req1_b  : req0_b;

  // One full-adder cell. SUB/CMP add ~b with carry-in 1 (two's complement).
  always_comb begin
    bit_a   = a_q[bit_cnt_q];
    bit_b   = (op_q == OP_ADD) ? b_q[bit_cnt_q] : ~b_q[bit_cnt_q];
    sum_bit = bit_a ^ bit_b ^ carry_q;
    carry_d = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
    zero_d  = zero_q & ~sum_bit;
    sum_d   = sum_q;
    sum_d[bit_cnt_q] = sum_bit;
  end

  // Result word formed from the values after the final bit; carry_d is the
  // carry out of the MSB, and borrow is its complement.
  always_comb begin
    result_d = '0;
    case (op_q)
      OP_ADD: result_d = {carry_d, sum_d};
      OP_SUB: result_d = {~carry_d, sum_d};
      OP_CMP: begin
        result_d[0] = ~carry_d;
        result_d[1] = zero_d;
        result_d[2] = carry_d & ~zero_d;
      end
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      id_q         <= 1'b0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      bit_cnt_q    <= '0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            id_q         <= grant1;
            last_grant_q <= grant1;
            op_q         <= op_in;
            a_q          <= a_in;
            b_q          <= b_in;
            sum_q        <= '0;
            bit_cnt_q    <= '0;
            carry_q      <= (op_in == OP_SUB) || (op_in == OP_CMP);
            zero_q       <= 1'b1;
          end
        end
        CALC: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          carry_q   <= carry_d;
          zero_q    <= zero_d;
          sum_q     <= sum_d;
          if (last_bit) begin
            rsp_result <= result_d;
            rsp_err    <= (op_q == OP_RSV);
            rsp_id     <= id_q;
          end
        end
        DONE: begin
          // Response fields return to 0 once consumed.
          if (rsp_ready) begin
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp_id     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_serial_sched.sv
module tb_alu_rr_serial_sched;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W:0]   rsp_result;

  int   vectors = 0;
  int   miscompares = 0;
  logic model_last = 1'b1;

  always #5 clk = ~clk;

  alu_rr_serial_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  // Reference result from plain arithmetic on the operands.
  function automatic logic [W:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = '0;
    case (op)
      2'b00: r = {1'b0, a} + {1'b0, b};
      2'b01: begin r[W-1:0] = a - b; r[W] = (a < b); end
      2'b10: begin r[0] = (a < b); r[1] = (a == b); r[2] = (a > b); end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Round-robin expectation: alternate under contention, else the lone valid one.
  function automatic int ref_grant(input bit v0, input bit v1);
    if (v0 && v1) return model_last ? 0 : 1;
    return v1 ? 1 : 0;
  endfunction

  // Drives one request pair and collects the outcome (no checking here).
  // gid: 0/1 accepted requester, 2 both ready, -1 none. lat: edges from
  // accept to rsp_valid, -1 if no response.
  task automatic issue(input bit v0, input logic [1:0] o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input bit v1, input logic [1:0] o1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       output int gid, output int lat, output logic [W:0] res,
                       output logic id, output logic err, output time t_acc);
    gid = -1; lat = -1; res = '0; id = 1'b0; err = 1'b0; t_acc = 0;
    @(negedge clk);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    for (int i = 0; i < 20 && gid < 0; i++) begin
      #1;
      if (req0_valid && req0_ready && req1_valid && req1_ready) gid = 2;
      else if (req0_valid && req0_ready)                        gid = 0;
      else if (req1_valid && req1_ready)                        gid = 1;
      if (gid < 0) @(negedge clk);
    end
    if (gid >= 0) begin
      @(posedge clk);
      t_acc = $time;
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (gid < 0) return;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin lat = i; break; end
      @(posedge clk);
      @(negedge clk);
    end
    if (lat >= 0) begin
      res = rsp_result; id = rsp_id; err = rsp_err;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result, req0_ready, req1_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b id=%b err=%b result=%b rdy=%b%b, want all 0",
               rsp_valid, rsp_id, rsp_err, rsp_result, req0_ready, req1_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL first_grant: got ready0/1=%b%b, want 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_sub_add();
    logic [1:0]   ops [3] = '{2'b01, 2'b01, 2'b00};
    logic [W-1:0] as  [3] = '{4'd5, 4'd3, 4'd15};
    logic [W-1:0] bs  [3] = '{4'd3, 4'd5, 4'd1};
    logic [W:0]   exp [3] = '{5'b00010, 5'b11110, 5'b10000};
    bit           use1[3] = '{1'b0, 1'b1, 1'b1};
    int gid, lat; logic [W:0] res; logic id, err; time t;
    for (int i = 0; i < 3; i++) begin
      issue(!use1[i], ops[i], as[i], bs[i], use1[i], ops[i], as[i], bs[i], gid, lat, res, id, err, t);
      model_last = use1[i];
      vectors++;
      if (gid !== int'(use1[i])) begin
        miscompares++;
        $display("FAIL subadd_grant[%0d]: got %0d, want %0d", i, gid, use1[i]);
      end
      vectors++;
      if (lat !== W) begin
        miscompares++;
        $display("FAIL subadd_latency[%0d]: got %0d, want %0d", i, lat, W);
      end
      vectors++;
      if ({id, err, res} !== {use1[i], 1'b0, exp[i]}) begin
        miscompares++;
        $display("FAIL subadd_result[%0d]: got id=%b err=%b res=%b, want id=%b err=0 res=%b",
                 i, id, err, res, use1[i], exp[i]);
      end
    end
  endtask

  task automatic test_cmp();
    logic [W-1:0] as  [3] = '{4'd7, 4'd2, 4'd9};
    logic [W-1:0] bs  [3] = '{4'd7, 4'd9, 4'd2};
    logic [W:0]   exp [3] = '{5'b00010, 5'b00001, 5'b00100};
    int gid, lat; logic [W:0] res; logic id, err; time t;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 2'b10, as[i], bs[i], 1'b0, 2'b00, '0, '0, gid, lat, res, id, err, t);
      model_last = 1'b0;
      vectors++;
      if (gid !== 0 || lat !== W || {id, err, res} !== {1'b0, 1'b0, exp[i]}) begin
        miscompares++;
        $display("FAIL cmp[%0d]: got grant=%0d lat=%0d id=%b err=%b res=%b, want grant=0 lat=%0d id=0 err=0 res=%b",
                 i, gid, lat, id, err, res, W, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gid, lat, eg; logic [W:0] res, er; logic id, err; time t, tprev;
    logic [1:0] o0, o1; logic [W-1:0] a0, b0, a1, b1;
    tprev = 0;
    for (int i = 0; i < 6; i++) begin
      o0 = 2'($urandom_range(0, 2)); o1 = 2'($urandom_range(0, 2));
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      if (a1 == a0) a1 = a0 + 1'b1;
      eg = ref_grant(1'b1, 1'b1);
      er = (eg == 1) ? ref_result(o1, a1, b1) : ref_result(o0, a0, b0);
      issue(1'b1, o0, a0, b0, 1'b1, o1, a1, b1, gid, lat, res, id, err, t);
      model_last = eg[0];
      vectors++;
      if (gid !== eg) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got %0d, want %0d", i, gid, eg);
      end
      vectors++;
      if ({id, err, res} !== {eg[0], 1'b0, er}) begin
        miscompares++;
        $display("FAIL rr_result[%0d]: got id=%b err=%b res=%b, want id=%b err=0 res=%b", i, id, err, res, eg[0], er);
      end
      if (i > 0) begin
        vectors++;
        if (t - tprev !== 60) begin
          miscompares++;
          $display("FAIL rr_spacing[%0d]: got %0t, want 60", i, t - tprev);
        end
      end
      tprev = t;
    end
  endtask

  task automatic test_stall();
    logic [W:0] e1, e2; bit ok;
    e1 = ref_result(2'b00, 4'd6, 4'd7);
    e2 = ref_result(2'b01, 4'd9, 4'd4);
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'd6; req0_b = 4'd7;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin #1; ok = req0_ready; if (!ok) @(negedge clk); end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stall_accept: got no grant, want req0 granted"); return; end
    @(posedge clk);
    model_last = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 4'd9; req1_b = 4'd4;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin #1; ok = rsp_valid; if (!ok) @(negedge clk); end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_result, req0_ready, req1_ready} !== {1'b1, 1'b0, 1'b0, e1, 2'b00}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got valid=%b id=%b err=%b res=%b rdy=%b%b, want 1 0 0 %b 00",
                 k, rsp_valid, rsp_id, rsp_err, rsp_result, req0_ready, req1_ready, e1);
      end
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL stall_resume: got valid=%b rdy=%b%b, want valid=0 rdy=01", rsp_valid, req0_ready, req1_ready);
    end
    @(posedge clk);
    model_last = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin #1; ok = rsp_valid; if (!ok) @(negedge clk); end
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 1'b1, 1'b0, e2}) begin
      miscompares++;
      $display("FAIL stall_next: got valid=%b id=%b err=%b res=%b, want 1 1 0 %b", rsp_valid, rsp_id, rsp_err, rsp_result, e2);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int gid, lat, seen; logic [W:0] res; logic id, err; time t; bit ok;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'd15; req0_b = 4'd15;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin #1; ok = req0_ready; if (!ok) @(negedge clk); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_last = 1'b1;
    #1;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result, req0_ready, req1_ready} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got valid=%b id=%b err=%b res=%b rdy=%b%b, want all 0",
               rsp_valid, rsp_id, rsp_err, rsp_result, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rsp_valid) seen++; end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midreset_noresp: got %0d valid cycles, want 0", seen);
    end
    issue(1'b1, 2'b11, 4'd5, 4'd3, 1'b0, 2'b00, '0, '0, gid, lat, res, id, err, t);
    model_last = 1'b0;
    vectors++;
    if (gid !== 0 || lat !== W || {id, err, res} !== {1'b0, 1'b1, {(W+1){1'b0}}}) begin
      miscompares++;
      $display("FAIL reserved_op: got grant=%0d lat=%0d id=%b err=%b res=%b, want grant=0 lat=%0d id=0 err=1 res=0",
               gid, lat, id, err, res, W);
    end
  endtask

  task automatic test_random();
    int gid, lat, eg; logic [W:0] res, er; logic id, err; time t;
    bit v0, v1; logic [1:0] o0, o1; logic [W-1:0] a0, b0, a1, b1;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      o0 = 2'($urandom); o1 = 2'($urandom);
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      eg = ref_grant(v0, v1);
      er = (eg == 1) ? ref_result(o1, a1, b1) : ref_result(o0, a0, b0);
      issue(v0, o0, a0, b0, v1, o1, a1, b1, gid, lat, res, id, err, t);
      model_last = eg[0];
      vectors++;
      if (gid !== eg || lat !== W) begin
        miscompares++;
        $display("FAIL rand_grant[%0d]: got grant=%0d lat=%0d, want grant=%0d lat=%0d", i, gid, lat, eg, W);
      end
      vectors++;
      if ({id, err, res} !== {eg[0], ((eg == 1) ? o1 : o0) == 2'b11, er}) begin
        miscompares++;
        $display("FAIL rand_result[%0d]: got id=%b err=%b res=%b, want id=%b res=%b", i, id, err, res, eg[0], er);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_sub_add();
    test_cmp();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
